// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV32I core: ID/EX control and index bundles,
// selector widths used by decode and execute, and the NOP encodings.
package pipeline_pkg;

   localparam int unsigned AluASelWidth   = 2;
   localparam int unsigned AluBSelWidth   = 1;
   localparam int unsigned NextPcSelWidth = 2;
   localparam int unsigned AluOpWidth     = 3;
   localparam int unsigned RegIdxWidth    = 5;
   localparam int unsigned Funct3Width    = 3;

   // next_pc_sel encoding 0 is PC+4, so an all-zero bundle never redirects.
   typedef struct packed {
      logic                      valid;
      logic                      write;
      logic                      store;
      logic                      load;
      logic                      branch;
      logic [AluASelWidth-1:0]   alu_a_sel;
      logic [AluBSelWidth-1:0]   alu_b_sel;
      logic [NextPcSelWidth-1:0] next_pc_sel;
      logic [AluOpWidth-1:0]     alu_op;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic [RegIdxWidth-1:0] rs1;
      logic [RegIdxWidth-1:0] rs2;
      logic [RegIdxWidth-1:0] rd;
      logic [Funct3Width-1:0] funct3;
   } id_ex_data_t;

   localparam id_ex_ctrl_t ID_EX_NOP      = '0;
   localparam id_ex_data_t ID_EX_DATA_NOP = '0;

   // True when the bundle has an architecturally visible side effect.
   function automatic logic has_side_effect(id_ex_ctrl_t c);
      return c.valid & (c.write | c.store | c.branch | (c.next_pc_sel != '0));
   endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check between the load in execute and the
// instruction in decode. Both source indices are always compared.
module load_use_detector
   import pipeline_pkg::*;
(
   input  logic                   ex_valid,
   input  logic                   ex_load,
   input  logic [RegIdxWidth-1:0] ex_rd,
   input  logic                   id_valid,
   input  logic [RegIdxWidth-1:0] id_rs1,
   input  logic [RegIdxWidth-1:0] id_rs2,
   output logic                   hazard
);

   logic load_in_ex;
   logic src_match;

   always_comb begin
      load_in_ex = ex_valid & ex_load & (ex_rd != '0);
      src_match  = (id_rs1 == ex_rd) | (id_rs2 == ex_rd);
      hazard     = load_in_ex & id_valid & src_match;
   end

endmodule

// File: rtl/id_ex_register.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// execute-flush squashing and a count of inserted bubbles.
module id_ex_register
   import pipeline_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic                      id_write,
   input  logic                      id_store,
   input  logic                      id_load,
   input  logic                      id_branch,
   input  logic [AluASelWidth-1:0]   id_alu_operand_a_selector,
   input  logic [AluBSelWidth-1:0]   id_alu_operand_b_selector,
   input  logic [NextPcSelWidth-1:0] id_next_pc_selector,
   input  logic [AluOpWidth-1:0]     id_alu_operations_selector,
   input  logic [XLEN-1:0]           id_pc,
   input  logic [XLEN-1:0]           id_rs1_data,
   input  logic [XLEN-1:0]           id_rs2_data,
   input  logic [XLEN-1:0]           id_immediate,
   input  logic [RegIdxWidth-1:0]    id_rs1,
   input  logic [RegIdxWidth-1:0]    id_rs2,
   input  logic [RegIdxWidth-1:0]    id_rd,
   input  logic [Funct3Width-1:0]    id_funct3,
   input  logic                      ex_flush,
   output logic                      decode_stall,
   output logic                      ex_valid,
   output logic                      ex_write,
   output logic                      ex_store,
   output logic                      ex_load,
   output logic                      ex_branch,
   output logic [AluASelWidth-1:0]   ex_alu_operand_a_selector,
   output logic [AluBSelWidth-1:0]   ex_alu_operand_b_selector,
   output logic [NextPcSelWidth-1:0] ex_next_pc_selector,
   output logic [AluOpWidth-1:0]     ex_alu_operations_selector,
   output logic [XLEN-1:0]           ex_pc,
   output logic [XLEN-1:0]           ex_rs1_data,
   output logic [XLEN-1:0]           ex_rs2_data,
   output logic [XLEN-1:0]           ex_immediate,
   output logic [RegIdxWidth-1:0]    ex_rs1,
   output logic [RegIdxWidth-1:0]    ex_rs2,
   output logic [RegIdxWidth-1:0]    ex_rd,
   output logic [Funct3Width-1:0]    ex_funct3,
   output logic [31:0]               bubble_count
);

   id_ex_ctrl_t     id_ctrl, ctrl_d, ctrl_q;
   id_ex_data_t     id_idx, idx_d, idx_q;
   logic [XLEN-1:0] pc_d, pc_q;
   logic [XLEN-1:0] rs1_data_d, rs1_data_q;
   logic [XLEN-1:0] rs2_data_d, rs2_data_q;
   logic [XLEN-1:0] imm_d, imm_q;
   logic [31:0]     bubble_d, bubble_q;
   logic            hazard;

   always_comb begin
      id_ctrl = '{
         valid:       id_valid,
         write:       id_write,
         store:       id_store,
         load:        id_load,
         branch:      id_branch,
         alu_a_sel:   id_alu_operand_a_selector,
         alu_b_sel:   id_alu_operand_b_selector,
         next_pc_sel: id_next_pc_selector,
         alu_op:      id_alu_operations_selector
      };
      id_idx = '{
         rs1:    id_rs1,
         rs2:    id_rs2,
         rd:     id_rd,
         funct3: id_funct3
      };
   end

   load_use_detector u_load_use_detector (
      .ex_valid (ctrl_q.valid),
      .ex_load  (ctrl_q.load),
      .ex_rd    (idx_q.rd),
      .id_valid (id_valid),
      .id_rs1   (id_rs1),
      .id_rs2   (id_rs2),
      .hazard   (hazard)
   );

   // A flush squashes decode upstream too, so there is nothing to hold.
   assign decode_stall = hazard & ~ex_flush;

   always_comb begin
      ctrl_d     = ID_EX_NOP;
      idx_d      = ID_EX_DATA_NOP;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      bubble_d   = bubble_q;
      if (ex_flush) begin
         // NOP defaults stand; flush outranks the hazard.
      end else if (hazard) begin
         bubble_d = bubble_q + 32'd1;
      end else begin
         ctrl_d     = id_ctrl;
         idx_d      = id_idx;
         pc_d       = id_pc;
         rs1_data_d = id_rs1_data;
         rs2_data_d = id_rs2_data;
         imm_d      = id_immediate;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q     <= ID_EX_NOP;
         idx_q      <= ID_EX_DATA_NOP;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         bubble_q   <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         idx_q      <= idx_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         bubble_q   <= bubble_d;
      end
   end

   assign ex_valid                   = ctrl_q.valid;
   assign ex_write                   = ctrl_q.write;
   assign ex_store                   = ctrl_q.store;
   assign ex_load                    = ctrl_q.load;
   assign ex_branch                  = ctrl_q.branch;
   assign ex_alu_operand_a_selector  = ctrl_q.alu_a_sel;
   assign ex_alu_operand_b_selector  = ctrl_q.alu_b_sel;
   assign ex_next_pc_selector        = ctrl_q.next_pc_sel;
   assign ex_alu_operations_selector = ctrl_q.alu_op;
   assign ex_pc                      = pc_q;
   assign ex_rs1_data                = rs1_data_q;
   assign ex_rs2_data                = rs2_data_q;
   assign ex_immediate               = imm_q;
   assign ex_rs1                     = idx_q.rs1;
   assign ex_rs2                     = idx_q.rs2;
   assign ex_rd                      = idx_q.rd;
   assign ex_funct3                  = idx_q.funct3;
   assign bubble_count               = bubble_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed load-use/flush/wrap scenarios plus
// randomized traffic, all compared against an instruction-level model.
module tb_id_ex_register;

   typedef struct packed {
      logic        valid, write, store, load, branch;
      logic [1:0]  a_sel;
      logic        b_sel;
      logic [1:0]  npc_sel;
      logic [2:0]  alu_op;
      logic [31:0] pc, rs1_data, rs2_data, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  funct3;
   } instr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, ex_flush, decode_stall;
   instr_t      id;
   logic        ex_valid, ex_write, ex_store, ex_load, ex_branch;
   logic [1:0]  ex_a, ex_npc;
   logic        ex_b;
   logic [2:0]  ex_op, ex_funct3;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_immediate, bubble_count;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;

   id_ex_register #(.XLEN(32)) dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .id_valid                   (id.valid),
      .id_write                   (id.write),
      .id_store                   (id.store),
      .id_load                    (id.load),
      .id_branch                  (id.branch),
      .id_alu_operand_a_selector  (id.a_sel),
      .id_alu_operand_b_selector  (id.b_sel),
      .id_next_pc_selector        (id.npc_sel),
      .id_alu_operations_selector (id.alu_op),
      .id_pc                      (id.pc),
      .id_rs1_data                (id.rs1_data),
      .id_rs2_data                (id.rs2_data),
      .id_immediate               (id.imm),
      .id_rs1                     (id.rs1),
      .id_rs2                     (id.rs2),
      .id_rd                      (id.rd),
      .id_funct3                  (id.funct3),
      .ex_flush                   (ex_flush),
      .decode_stall               (decode_stall),
      .ex_valid                   (ex_valid),
      .ex_write                   (ex_write),
      .ex_store                   (ex_store),
      .ex_load                    (ex_load),
      .ex_branch                  (ex_branch),
      .ex_alu_operand_a_selector  (ex_a),
      .ex_alu_operand_b_selector  (ex_b),
      .ex_next_pc_selector        (ex_npc),
      .ex_alu_operations_selector (ex_op),
      .ex_pc                      (ex_pc),
      .ex_rs1_data                (ex_rs1_data),
      .ex_rs2_data                (ex_rs2_data),
      .ex_immediate               (ex_immediate),
      .ex_rs1                     (ex_rs1),
      .ex_rs2                     (ex_rs2),
      .ex_rd                      (ex_rd),
      .ex_funct3                  (ex_funct3),
      .bubble_count               (bubble_count)
   );

   // Model: the instruction sitting in execute (all-zero = NOP) and a bubble tally.
   instr_t      m_ex;
   logic [31:0] m_bubbles;
   bit          m_known = 0;
   int          n_pass = 0;
   int          n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic model_hazard(input instr_t ex, input instr_t nx);
      return ex.valid && ex.load && ex.rd != 5'd0 && nx.valid &&
             (nx.rs1 == ex.rd || nx.rs2 == ex.rd);
   endfunction

   task automatic check_outputs();
      chk("ex_valid",     ex_valid,     m_ex.valid);
      chk("ex_write",     ex_write,     m_ex.write);
      chk("ex_store",     ex_store,     m_ex.store);
      chk("ex_load",      ex_load,      m_ex.load);
      chk("ex_branch",    ex_branch,    m_ex.branch);
      chk("ex_a_sel",     ex_a,         m_ex.a_sel);
      chk("ex_b_sel",     ex_b,         m_ex.b_sel);
      chk("ex_npc_sel",   ex_npc,       m_ex.npc_sel);
      chk("ex_alu_op",    ex_op,        m_ex.alu_op);
      chk("ex_pc",        ex_pc,        m_ex.pc);
      chk("ex_rs1_data",  ex_rs1_data,  m_ex.rs1_data);
      chk("ex_rs2_data",  ex_rs2_data,  m_ex.rs2_data);
      chk("ex_immediate", ex_immediate, m_ex.imm);
      chk("ex_rs1",       ex_rs1,       m_ex.rs1);
      chk("ex_rs2",       ex_rs2,       m_ex.rs2);
      chk("ex_rd",        ex_rd,        m_ex.rd);
      chk("ex_funct3",    ex_funct3,    m_ex.funct3);
      chk("bubble_count", bubble_count, m_bubbles);
   endtask

   // One clock: drive at the negedge, check the stall mid-cycle, step the
   // model across the posedge, then check the registered outputs.
   task automatic cycle(input instr_t s, input logic fl, input logic rn);
      logic hz;
      id       = s;
      ex_flush = fl;
      rst_n    = rn;
      #1;
      hz = model_hazard(m_ex, s);
      if (m_known) chk("decode_stall", decode_stall, hz && !fl);
      @(posedge clk);
      if (!rn || fl) m_ex = '0;
      else if (hz) begin
         m_ex = '0;
         m_bubbles = m_bubbles + 32'd1;
      end else m_ex = s;
      if (!rn) begin
         m_bubbles = '0;
         m_known   = 1;
      end
      #1;
      if (m_known) check_outputs();
      @(negedge clk);
   endtask

   function automatic instr_t rand_instr();
      instr_t r;
      r = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      r.valid = ($urandom_range(0, 9) != 0);
      r.load  = $urandom_range(0, 1);
      r.rs1   = 5'($urandom_range(0, 3));
      r.rs2   = 5'($urandom_range(0, 3));
      r.rd    = 5'($urandom_range(0, 3));
      return r;
   endfunction

   function automatic instr_t mk(input logic load, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2);
      instr_t r = '0;
      r.valid = 1;
      r.write = 1;
      r.load  = load;
      r.rd    = rd;
      r.rs1   = rs1;
      r.rs2   = rs2;
      return r;
   endfunction

   task automatic do_reset();
      cycle(rand_instr(), 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b1);
   endtask

   instr_t lw5, add_dep, i;

   initial begin
      id = '0; ex_flush = 0; rst_n = 0;
      m_ex = '0; m_bubbles = '0;
      @(negedge clk);

      // Reset held two cycles with random inputs, then released idle.
      cycle(rand_instr(), 1'b0, 1'b0);
      cycle(rand_instr(), 1'b1, 1'b0);
      cycle('0, 1'b0, 1'b1);
      chk("rst ex_valid", ex_valid, 0);
      chk("rst bubbles", bubble_count, 0);
      chk("rst stall", decode_stall, 0);

      // lw x5 ; add x6,x5,x7 -> exactly one bubble.
      lw5     = mk(1, 5, 1, 0);
      add_dep = mk(0, 6, 5, 7);
      cycle(lw5, 0, 1);
      id = add_dep; #1;
      chk("lu stall", decode_stall, 1);
      cycle(add_dep, 0, 1);
      chk("lu bubble valid", ex_valid, 0);
      cycle(add_dep, 0, 1);
      chk("lu ex_rs1", ex_rs1, 5);
      chk("lu ex_valid", ex_valid, 1);
      chk("lu bubbles", bubble_count, 1);

      // lw x0 never stalls; independent consumer never stalls.
      do_reset();
      cycle(mk(1, 0, 1, 0), 0, 1);
      id = mk(0, 6, 0, 0); #1;
      chk("x0 stall", decode_stall, 0);
      cycle(mk(0, 6, 0, 0), 0, 1);
      cycle(lw5, 0, 1);
      cycle(mk(0, 6, 7, 8), 0, 1);
      chk("indep bubbles", bubble_count, 0);

      // Flush during a pending hazard wins.
      cycle(lw5, 0, 1);
      id = add_dep; ex_flush = 1; #1;
      chk("flush stall", decode_stall, 0);
      cycle(add_dep, 1, 1);
      chk("flush ex_valid", ex_valid, 0);
      chk("flush bubbles", bubble_count, 0);

      // Pass-through of add x1.
      i = mk(0, 1, 2, 3);
      i.pc = 32'h100; i.imm = 32'hFFFF_FFF0;
      cycle(i, 0, 1);
      chk("pt ex_pc", ex_pc, 32'h100);
      chk("pt ex_imm", ex_immediate, 32'hFFFF_FFF0);
      chk("pt ex_write", ex_write, 1);
      chk("pt ex_valid", ex_valid, 1);

      // Reset mid-stall clears the register; stall gone next cycle.
      cycle(lw5, 0, 1);
      cycle(add_dep, 1, 0);
      id = add_dep; #1;
      chk("rst mid-stall", decode_stall, 0);
      cycle(add_dep, 0, 1);

      // Counter wrap: hold the counter at all-ones across one capturing edge.
      do_reset();
      force dut.bubble_q = 32'hFFFF_FFFF;
      m_bubbles = 32'hFFFF_FFFF;
      cycle(lw5, 0, 1);
      release dut.bubble_q;
      cycle(add_dep, 0, 1);
      chk("wrap bubbles", bubble_count, 0);
      cycle(add_dep, 0, 1);

      // Randomized traffic with occasional flush and reset.
      for (int n = 0; n < 600; n++) begin
         cycle(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

Decode-to-execute pipeline register of the 5-stage RV32I core. Captures the decoded control bundle (write/store/load/branch, ALU operand selectors, next-PC selector, ALU operation) plus operands and register indices at the end of decode. It detects load-use hazards against the instruction currently in execute and inserts a bubble. It also squashes on a taken branch or jump resolved in execute.

## Interface
- `XLEN`, default 32: datapath width
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset; one clock, synchronous, active-low
- `id_valid` in 1: decode holds a real instruction
- `id_write`, `id_store`, `id_load`, `id_branch` in 1 each: control flags from decode
- `id_alu_operand_a_selector` in 2; `id_alu_operand_b_selector` in 1; `id_next_pc_selector` in 2; `id_alu_operations_selector` in 3
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_immediate` in XLEN
- `id_rs1`, `id_rs2`, `id_rd` in 5; `id_funct3` in 3
- `ex_flush` in 1: taken branch/jump resolved in execute this cycle
- `decode_stall` out 1: hold PC and IF/ID register this cycle
- `ex_valid` out 1, plus `ex_*` outputs mirroring every `id_*` input above (same widths), registered
- `bubble_count` out 32: number of bubbles inserted by load-use hazards, wraps modulo 2^32

## Operation
- Load-use hazard (combinational): `hazard = ex_valid & ex_load & (ex_rd != 0) & id_valid & ((id_rs1 == ex_rd) | (id_rs2 == ex_rd))`.
  - The comparison is conservative. Both source indices are compared regardless of instruction type, so a spurious stall, for example on LUI/JAL, is required behaviour.
- `decode_stall = hazard & ~ex_flush`.
- Per-cycle update priority:
  1. `rst_n == 0`: load NOP.
  2. `ex_flush`: load NOP.
  3. `hazard`: load NOP (bubble) and increment `bubble_count`.
  4. Otherwise: capture all `id_*` inputs, with `ex_valid <= id_valid`.
- NOP means:
  - `ex_valid = 0` and all control flags 0.
  - All selectors set to encoding 0; `next_pc_selector` 0 is PC+4.
  - All data, index and `funct3` fields 0.
- A NOP never writes the register file or memory and never redirects the PC.
- `id_valid == 0` with no hazard or flush is captured as-is: controls pass through, `ex_valid = 0`. Execute qualifies every side effect with `ex_valid`.
- Flush during a hazard: the flush wins, `decode_stall = 0`, and `bubble_count` is not incremented. Upstream squashes IF/ID on the same `ex_flush`.
- After a bubble, the next cycle re-evaluates the hazard. The bubbled load has left execute, so the stalled instruction is captured. This gives exactly one bubble per load-use pair.

## Timing
- Reset values:
  - All `ex_*` outputs 0, including `ex_valid`.
  - `bubble_count` 0.
  - `decode_stall` 0, since `ex_valid` is 0.
- Latency: `id_*` to `ex_*` is 1 cycle, updated on the rising edge.
- `decode_stall` is combinational in the same cycle as `hazard`. It must settle before the edge that would otherwise advance IF/ID.
- Reset mid-stall: the next edge clears the register and `decode_stall` deasserts in the following cycle. Reset outranks `ex_flush`.
- `bubble_count` increments on the same edge that loads the bubble. It wraps 0xFFFF_FFFF to 0.

## Structure
- Shared package `pipeline_pkg` holds:
  - `id_ex_ctrl_t`, a packed struct of the nine control fields.
  - `id_ex_data_t` for the operand and index fields.
  - A `ID_EX_NOP` constant.
  - Selector width localparams (2/1/2/3), reused by decode and execute.
- One sub-module, `load_use_detector`, purely combinational. It produces `hazard` from `ex_valid`, `ex_load`, `ex_rd`, `id_valid`, `id_rs1` and `id_rs2`.
- The register, priority mux and counter live in `id_ex_register`.

## Test plan
- Reset held 2 cycles with random `id_*` inputs, then released with `id_valid=0` → all `ex_*` 0, `bubble_count` 0, `decode_stall` 0.
- Sequence: `lw x5`, then `add x6,x5,x7` → one cycle with `decode_stall=1`; execute sees a NOP, then `add` with `ex_rs1=5`; `bubble_count` = 1.
- Sequence: `lw x0`, then `add x6,x0,x0` → no stall, `bubble_count` stays 0. Separately, `lw x5` then `add x6,x7,x8` → no stall.
- Hazard pending with `ex_flush=1` on the same cycle → `decode_stall=0`, `ex_valid=0` next cycle, `bubble_count` unchanged.
- `add x1` passes through with `id_pc=0x100`, `id_immediate=0xFFFF_FFF0` → next cycle `ex_pc=0x100`, `ex_immediate=0xFFFF_FFF0`, `ex_write=1`, `ex_valid=1`.
- Force `bubble_count` to 0xFFFF_FFFF, then cause one load-use stall → `bubble_count` wraps to 0.
